// File: rtl/video_zone_adjust_if.sv
// Pixel-stream bus for video_zone_adjust: control inputs, {VS,HS,DEN,R,G,B}
// input and output streams, and the sticky line-length error flag.
interface video_zone_adjust_if #(
  parameter int CW = 8
);
  logic              en_cc;
  logic              en_tp;
  logic [CW-1:0]     brig;
  logic [3*CW+2:0]   dpi;
  logic [3*CW+2:0]   dpo;
  logic              line_err;

  modport master (
    output en_cc, en_tp, brig, dpi,
    input  dpo, line_err
  );

  modport slave (
    input  en_cc, en_tp, brig, dpi,
    output dpo, line_err
  );
endinterface

// File: rtl/video_zone_adjust.sv
// Zone brightness ramp / colour-bar test pattern on an RGB pixel stream.
// Position is recovered from DEN falling and VS rising edges; the bottom half
// of the frame uses a mirrored ramp followed by inversion. Fixed 3-cycle
// latency: stage 1 position capture, stage 2 arithmetic, stage 3 output.
module video_zone_adjust #(
  parameter int CW    = 8,
  parameter int H_ACT = 1920,
  parameter int V_ACT = 1080,
  parameter int ZONES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  video_zone_adjust_if.slave   bus
);

  localparam int DW  = 3*CW+3;
  localparam int HW  = $clog2(H_ACT+1)+1;
  localparam int VW  = $clog2(V_ACT+1);
  localparam int ZW  = $clog2(ZONES);
  localparam int ZPW = H_ACT/ZONES;
  localparam int PW  = (ZPW > 1) ? $clog2(ZPW) : 1;
  localparam int SW  = CW+5;

  localparam logic [HW-1:0]        H_LEN  = HW'(H_ACT);
  localparam logic [HW-1:0]        H_MAX  = '1;
  localparam logic [VW-1:0]        V_LAST = VW'(V_ACT);
  localparam logic [VW-1:0]        V_HALF = VW'(V_ACT/2);
  localparam logic [PW-1:0]        P_LAST = PW'(ZPW-1);
  localparam logic [ZW-1:0]        Z_LAST = ZW'(ZONES-1);
  localparam logic [CW-1:0]        C_MAX  = '1;
  localparam logic signed [SW-1:0] S_MAX  = {5'b00000, C_MAX};
  localparam logic signed [SW-1:0] K_BIAS = SW'(ZONES);

  // Add a signed offset to one channel, clamp to the channel range and
  // optionally invert the clamped result.
  function automatic logic [CW-1:0] f_adj(input logic [CW-1:0] x,
                                          input logic signed [SW-1:0] off,
                                          input logic inv);
    logic signed [SW-1:0] s;
    logic [CW-1:0]        y;
    s = $signed({5'b00000, x}) + off;
    if (s[SW-1]) begin
      y = '0;
    end else if (s > S_MAX) begin
      y = C_MAX;
    end else begin
      y = s[CW-1:0];
    end
    if (inv) begin
      f_adj = C_MAX - y;
    end else begin
      f_adj = y;
    end
  endfunction

  // Input stream fields
  logic              w_vs;
  logic              w_hs;
  logic              w_den;
  logic [3*CW-1:0]   w_rgb;
  assign {w_vs, w_hs, w_den, w_rgb} = bus.dpi;

  // Position / shadow state
  logic              r_vs_d;
  logic              r_den_d;
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic [PW-1:0]     r_pos;
  logic [ZW-1:0]     r_z;
  logic              r_armed;
  logic              r_sh_cc;
  logic              r_sh_tp;
  logic [CW-1:0]     r_sh_brig;
  logic              r_line_err;

  logic              w_vs_rise;
  logic              w_den_fall;
  logic              w_len_bad;
  assign w_vs_rise  = w_vs & ~r_vs_d;
  assign w_den_fall = ~w_den & r_den_d;
  assign w_len_bad  = w_den_fall & r_armed & (r_h != H_LEN);

  // Effective position and settings of the current pixel; a VS rise restarts
  // the frame on this very pixel and takes the new control values.
  logic [HW-1:0]     w_h_cur;
  logic [VW-1:0]     w_v_cur;
  logic [PW-1:0]     w_pos_cur;
  logic [ZW-1:0]     w_z_cur;
  logic              w_cc;
  logic              w_tp;
  logic [CW-1:0]     w_brig;

  // Select current pixel position and mode settings
  always_comb begin
    if (w_vs_rise) begin
      w_h_cur   = '0;
      w_v_cur   = '0;
      w_pos_cur = '0;
      w_z_cur   = '0;
      w_cc      = bus.en_cc;
      w_tp      = bus.en_tp;
      w_brig    = bus.brig;
    end else begin
      w_h_cur   = r_h;
      w_v_cur   = r_v;
      w_pos_cur = r_pos;
      w_z_cur   = r_z;
      w_cc      = r_sh_cc;
      w_tp      = r_sh_tp;
      w_brig    = r_sh_brig;
    end
  end

  // Position after this pixel when DEN is high (zone tracked incrementally)
  logic [HW-1:0]     w_h_nxt;
  logic [PW-1:0]     w_pos_nxt;
  logic [ZW-1:0]     w_z_nxt;

  // Advance horizontal count and zone counters
  always_comb begin
    w_h_nxt = (w_h_cur == H_MAX) ? H_MAX : w_h_cur + HW'(1);
    if (w_pos_cur == P_LAST) begin
      w_pos_nxt = '0;
      w_z_nxt   = (w_z_cur == Z_LAST) ? Z_LAST : w_z_cur + ZW'(1);
    end else begin
      w_pos_nxt = w_pos_cur + PW'(1);
      w_z_nxt   = w_z_cur;
    end
  end

  // Track h/v position, frame arming and shadowed controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d    <= 1'b0;
      r_den_d   <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_pos     <= '0;
      r_z       <= '0;
      r_armed   <= 1'b0;
      r_sh_cc   <= 1'b0;
      r_sh_tp   <= 1'b0;
      r_sh_brig <= '0;
    end else begin
      r_vs_d  <= w_vs;
      r_den_d <= w_den;
      if (w_den) begin
        r_h   <= w_h_nxt;
        r_pos <= w_pos_nxt;
        r_z   <= w_z_nxt;
      end else if (w_vs_rise | w_den_fall) begin
        r_h   <= '0;
        r_pos <= '0;
        r_z   <= '0;
      end else begin
        r_h   <= r_h;
        r_pos <= r_pos;
        r_z   <= r_z;
      end
      if (w_vs_rise) begin
        r_v <= '0;
      end else if (w_den_fall && (r_v != V_LAST)) begin
        r_v <= r_v + VW'(1);
      end else begin
        r_v <= r_v;
      end
      r_armed   <= r_armed | w_vs_rise;
      r_sh_cc   <= w_cc;
      r_sh_tp   <= w_tp;
      r_sh_brig <= w_brig;
    end
  end

  // Sticky line-length error, cleared by a VS rise unless set the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_err <= 1'b0;
    end else if (w_len_bad) begin
      r_line_err <= 1'b1;
    end else if (w_vs_rise) begin
      r_line_err <= 1'b0;
    end else begin
      r_line_err <= r_line_err;
    end
  end

  // Stage 1 registers
  logic [2:0]        r1_sync;
  logic [3*CW-1:0]   r1_rgb;
  logic [ZW-1:0]     r1_z;
  logic              r1_bot;
  logic              r1_cc;
  logic              r1_tp;
  logic [CW-1:0]     r1_brig;

  // Stage 1: capture pixel together with its zone, half and mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_sync <= '0;
      r1_rgb  <= '0;
      r1_z    <= '0;
      r1_bot  <= 1'b0;
      r1_cc   <= 1'b0;
      r1_tp   <= 1'b0;
      r1_brig <= '0;
    end else begin
      r1_sync <= {w_vs, w_hs, w_den};
      r1_rgb  <= w_rgb;
      r1_z    <= w_z_cur;
      r1_bot  <= (w_v_cur >= V_HALF);
      r1_cc   <= w_cc;
      r1_tp   <= w_tp;
      r1_brig <= w_brig;
    end
  end

  // Stage 2 arithmetic
  logic [ZW-1:0]        w_zi;
  logic signed [SW-1:0] w_k;
  logic signed [SW-1:0] w_prod;
  logic signed [SW-1:0] w_off;
  logic [2:0]           w_z3;
  logic [3*CW-1:0]      w_tp_rgb;
  logic [3*CW-1:0]      w_cc_rgb;
  logic [3*CW-1:0]      w_rgb_out;

  // Zone ramp offset, per-channel clamp/invert, test pattern and mode select
  always_comb begin
    w_zi   = r1_bot ? (Z_LAST - r1_z) : r1_z;
    w_k    = $signed({{(SW-ZW-1){1'b0}}, w_zi, 1'b1}) - K_BIAS;
    w_prod = w_k * $signed({5'b00000, r1_brig});
    w_off  = w_prod >>> ZW;
    w_z3   = 3'b000;
    w_z3[ZW-1:0] = r1_z;
    w_tp_rgb = {{CW{w_z3[0]}}, {CW{w_z3[1]}}, {CW{w_z3[2]}}};
    w_cc_rgb = {f_adj(r1_rgb[3*CW-1:2*CW], w_off, r1_bot),
                f_adj(r1_rgb[2*CW-1:CW],   w_off, r1_bot),
                f_adj(r1_rgb[CW-1:0],      w_off, r1_bot)};
    if (!r1_sync[0]) begin
      w_rgb_out = r1_rgb;
    end else if (r1_tp) begin
      w_rgb_out = w_tp_rgb;
    end else if (r1_cc) begin
      w_rgb_out = w_cc_rgb;
    end else begin
      w_rgb_out = r1_rgb;
    end
  end

  logic [2:0]        r2_sync;
  logic [3*CW-1:0]   r2_rgb;
  logic [DW-1:0]     r3_dpo;

  // Stage 2 register: processed pixel with delayed syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_sync <= '0;
      r2_rgb  <= '0;
    end else begin
      r2_sync <= r1_sync;
      r2_rgb  <= w_rgb_out;
    end
  end

  // Stage 3: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_dpo <= '0;
    end else begin
      r3_dpo <= {r2_sync, r2_rgb};
    end
  end

  assign bus.dpo      = r3_dpo;
  assign bus.line_err = r_line_err;

endmodule

// File: doc/video_zone_adjust.md
Name: video_zone_adjust

Overview:
- Parametrised successor to the fixed-1080p CC/TP front-end of the RGB display pipeline.
- Applies per-zone brightness ramps, with the bottom half mirrored and inverted, or a colour-bar test pattern on a {VS,HS,DEN,R,G,B} pixel stream.
- Pixel position comes from DEN/VS edges, not hard-coded wrap counts.
- Sits between the panel input and the downstream IM/IG/UM stages.

Parameters:
CW, 8, bits per colour channel
H_ACT, 1920, expected active pixels per line (DEN-high run length)
V_ACT, 1080, expected active lines per frame
ZONES, 4, horizontal zones; legal values 2, 4, 8; H_ACT divisible by ZONES

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset; asynchronous, active-low
en_cc  in  1  zone colour-adjust enable (shadowed)
en_tp  in  1  test-pattern enable (shadowed; overrides en_cc)
brig  in  CW  brightness strength (shadowed)
dpi  in  3*CW+3  {VS,HS,DEN,R,G,B}
dpo  out  3*CW+3  processed stream, same format
line_err  out  1  sticky: a line's DEN run length differed from H_ACT

Behaviour:
- Reset: dpo=0, line_err=0, counters=0, shadow brig=0, shadow enables=0, armed=0. All state is async-cleared.
- Latency: fixed 3 cycles in every mode.
  - Stage 1 registers the pixel with its h/v/zone.
  - Stage 2 does the arithmetic.
  - Stage 3 is the output register.
  - VS/HS/DEN are delayed identically.
- Position:
  - h = number of DEN-high cycles earlier in the current line.
  - DEN falling edge: h←0, v←v+1, saturating at V_ACT.
  - VS rising edge: h←0, v←0, armed←1.
  - When DEN and a VS rise coincide, the VS reset wins; that pixel is h=0, v=0.
- Zone: z = h / (H_ACT/ZONES), clamped to ZONES-1. Bottom half when v ≥ V_ACT/2.
- Shadow registers: en_cc, en_tp and brig are copied only on a VS rising edge. Mid-frame input changes have no effect until the next frame.
- DEN=0 cycles: RGB passes through unchanged in all modes.
- CC, when shadow en_cc=1 and en_tp=0:
  - Top half: zi = z. Bottom half: zi = ZONES-1-z.
  - off = ((2·zi+1-ZONES)·brig) >>> log2(ZONES), arithmetic shift (floor), signed width CW+5.
  - y = clamp(x+off, 0, 2^CW-1), per channel.
  - Bottom half output is (2^CW-1) - y.
- TP, when shadow en_tp=1: output R = z[0] ? max : 0, G = z[1] ? max : 0, B = z[2] ? max : 0 (z[2] = 0 for ZONES < 8). Input RGB is ignored.
- Neither enabled: RGB passes through unchanged.
- line_err:
  - Evaluated at each DEN falling edge when armed=1.
  - Set when the run length ≠ H_ACT; visible the cycle after the edge.
  - Cleared on the next VS rising edge unless the same cycle sets it.
  - Not evaluated before the first VS after reset.
- Reset mid-frame: counters restart at 0. Pixels are processed as h=0/v=0-relative until the next VS. No output glitch beyond dpo=0 while rst_n is low.
- HS is only delayed; it does not affect counters.

Test Plan:
All scenarios use CW=8, H_ACT=8, V_ACT=4, ZONES=4.
1. Reset low, then high with enables 0 → dpo=0, line_err=0 during reset. Input RGB 0x123456 with DEN=1 appears at dpo unchanged exactly 3 cycles later, syncs aligned.
2. VS pulse, then en_cc=1, brig=64, top line, all channels 100, with en_cc/brig applied via the next VS → pixels h0..7 output 52,52,84,84,116,116,148,148.
3. Same settings, line 2 (bottom half) → h0..7 output 107,107,139,139,171,171,203,203 (mirrored ramp, then inverted).
4. brig=255, top line: input 10 in zone 0 → 0 (offset -192, clamped). Input 250 in zone 3 → 255 (offset +191, clamped).
5. en_tp=1 effective → zones 0..3 output 0x000000, 0xFF0000, 0x00FF00, 0xFFFF00. Changing brig or en_tp mid-frame causes no output change until after the next VS rising edge.
6. After a VS, drive one line with a 7-cycle DEN run → line_err=1 the cycle after the DEN fall. It stays 1 through correct lines and clears after the next VS rise. A 7-cycle line before any VS since reset leaves line_err=0.
